// File: rtl/iram_loader.sv
// Byte-stream IRAM loader: takes a 16-bit word count and then big-endian 16-bit
// instructions, writes each one through the external IRAM port and gates the run enable.
module iram_loader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int BASE_ADDR  = 1,
  parameter int WRITE_HOLD = 4,
  parameter int MAX_WORDS  = 511
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              iram_write_ext,
  output logic [DATA_W-1:0] Data_in_ins,
  output logic              start_2,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int HOLD_W = (WRITE_HOLD < 2) ? 1 : $clog2(WRITE_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WRITE_HOLD - 1);
  localparam bit PARAM_OK = (DATA_W == 16) && (WRITE_HOLD >= 1) &&
                            ((BASE_ADDR + MAX_WORDS - 1) <= ((2 ** ADDR_W) - 1));

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_SETUP, S_WRITE, S_RECOVER, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       count;
  logic [HOLD_W-1:0] hold_cnt;
  logic [15:0]       count_full;
  logic [16:0]       wl_next;
  logic              consume, overrun, accept_load, count_bad, last_word;

  assign count_full = {count[15:8], byte_in};
  assign count_bad  = (count_full == 16'd0) || (count_full > 16'(MAX_WORDS));
  assign wl_next    = 17'(words_loaded) + 17'd1;
  assign last_word  = (wl_next == {1'b0, count});

  always_comb begin
    state_nxt      = state;
    byte_ready     = 1'b0;
    iram_write_ext = 1'b0;
    busy           = 1'b1;
    accept_load    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        busy        = 1'b0;
        accept_load = load_en;
        if (load_en) state_nxt = S_LEN_HI;
      end
      S_LEN_HI:  begin byte_ready = 1'b1; if (byte_valid) state_nxt = S_LEN_LO; end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = count_bad ? S_ERROR : S_DATA_HI;
      end
      S_DATA_HI: begin byte_ready = 1'b1; if (byte_valid) state_nxt = S_DATA_LO; end
      S_DATA_LO: begin byte_ready = 1'b1; if (byte_valid) state_nxt = S_SETUP; end
      S_SETUP:   state_nxt = S_WRITE;
      S_WRITE: begin
        iram_write_ext = 1'b1;
        if (hold_cnt == HOLD_LAST) state_nxt = S_RECOVER;
      end
      S_RECOVER: state_nxt = last_word ? S_DONE : S_DATA_HI;
      default:   state_nxt = S_IDLE;
    endcase
    start_2 = busy;
    consume = byte_valid && byte_ready;
    overrun = byte_valid && !byte_ready && busy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_ext     <= ADDR_W'(BASE_ADDR);
      Data_in_ins  <= '0;
      count        <= '0;
      hold_cnt     <= '0;
      words_loaded <= '0;
      start        <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == S_WRITE) ? hold_cnt + HOLD_W'(1) : '0;
      if (accept_load) begin
        addr_ext     <= ADDR_W'(BASE_ADDR);
        words_loaded <= '0;
        start        <= 1'b0;
        done         <= 1'b0;
        error        <= 1'b0;
      end else begin
        // start trails done by one cycle so IRAM is quiet before the core runs
        if (state == S_DONE) start <= 1'b1;
        if (state == S_RECOVER) begin
          addr_ext     <= addr_ext + ADDR_W'(1);
          words_loaded <= words_loaded + ADDR_W'(1);
          if (last_word) done <= 1'b1;
        end
        if (overrun || (state == S_LEN_LO && consume && count_bad)) error <= 1'b1;
      end
      if (consume) begin
        unique case (state)
          S_LEN_HI:  count[15:8] <= byte_in;
          S_LEN_LO:  count[7:0]  <= byte_in;
          S_DATA_HI: Data_in_ins[DATA_W-1 -: 8] <= byte_in;
          S_DATA_LO: Data_in_ins[7:0] <= byte_in;
          default: ;
        endcase
      end
    end
  end

  assert property (@(posedge clock) PARAM_OK)
    else $error("iram_loader: parameters allow the IRAM address to wrap");

endmodule

// File: tb/tb_iram_loader.sv
// Randomised bench for iram_loader: a transaction-level scoreboard of expected
// IRAM writes plus end-of-load status checks derived from the load's byte stream.
module tb_iram_loader;
  localparam int ADDR_W = 9, DATA_W = 16, BASE = 1, HOLD = 4, MAXW = 511;

  logic              clock = 1'b0;
  logic              reset, load_en, byte_valid;
  logic [7:0]        byte_in;
  logic              byte_ready, iram_write_ext, start_2, start, busy, done, error;
  logic [ADDR_W-1:0] addr_ext, words_loaded;
  logic [DATA_W-1:0] Data_in_ins;

  always #5 clock = ~clock;

  iram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE),
                .WRITE_HOLD(HOLD), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .addr_ext(addr_ext),
    .iram_write_ext(iram_write_ext), .Data_in_ins(Data_in_ins), .start_2(start_2),
    .start(start), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  typedef struct packed { logic [ADDR_W-1:0] a; logic [15:0] d; } wr_t;
  wr_t         exp_q[$];
  logic [15:0] wbuf[64];
  int          checks = 0, errors = 0, writes_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++; errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Write-pulse monitor: every pulse must be WRITE_HOLD long, stable, and match the scoreboard.
  initial begin
    bit in_pulse = 0; int run_len = 0; wr_t run, w;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        in_pulse = 0; run_len = 0;
      end else begin
        chk("start_2_vs_busy", start_2, busy);
        chk("ready_during_write", byte_ready & iram_write_ext, 0);
        if (iram_write_ext) begin
          if (!in_pulse) begin
            in_pulse = 1; run_len = 1; run.a = addr_ext; run.d = Data_in_ins;
          end else begin
            run_len++;
            chk("write_addr_stable", addr_ext, run.a);
            chk("write_data_stable", Data_in_ins, run.d);
          end
        end else if (in_pulse) begin
          in_pulse = 0;
          writes_seen++;
          chk("write_pulse_len", run_len, HOLD);
          if (exp_q.size() == 0) fail_now($sformatf("unexpected_write addr 0x%0h data 0x%0h", run.a, run.d));
          else begin
            w = exp_q.pop_front();
            chk("write_addr", run.a, w.a);
            chk("write_data", run.d, w.d);
          end
        end
      end
    end
  end

  task automatic tick(); @(posedge clock); #2; endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!byte_ready && n < 200) begin tick(); n++; end
    if (!byte_ready) begin fail_now("byte_ready_timeout"); return; end
    byte_in = b; byte_valid = 1'b1; tick(); byte_valid = 1'b0;
  endtask

  task automatic gap_wait(input int gfix);
    int g = (gfix >= 0) ? gfix : int'($urandom_range(0, 2));
    repeat (g) tick();
  endtask

  // One complete load: model predicts writes and final status from the count and words.
  task automatic run_load(input logic [15:0] cnt, input int gfix, input int ovr);
    bit bad = (cnt == 16'd0) || (int'(cnt) > MAXW);
    int n = bad ? 0 : int'(cnt);
    int k = 0;
    wr_t w;
    for (int i = 0; i < n; i++) begin w.a = ADDR_W'(BASE + i); w.d = wbuf[i]; exp_q.push_back(w); end
    load_en = 1'b1; tick(); load_en = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_start_2", start_2, 1);
    chk("load_start_cleared", start, 0);
    chk("load_done_cleared", done, 0);
    chk("load_error_cleared", error, 0);
    chk("load_words_cleared", words_loaded, 0);
    chk("load_addr_base", addr_ext, BASE);
    send_byte(cnt[15:8]); gap_wait(gfix); send_byte(cnt[7:0]); gap_wait(gfix);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i][15:8]); gap_wait(gfix); send_byte(wbuf[i][7:0]);
      if (i == ovr) begin
        k = 0;
        while (!iram_write_ext && k < 20) begin tick(); k++; end
        byte_in = 8'hEE; byte_valid = 1'b1; tick(); byte_valid = 1'b0;
      end
      gap_wait(gfix);
    end
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    if (busy) begin fail_now("busy_timeout"); return; end
    chk("end_start_first_cycle", start, 0);
    chk("end_start_2", start_2, 0);
    chk("end_queue_drained", exp_q.size(), 0);
    if (bad) begin
      chk("bad_error", error, 1);
      chk("bad_done", done, 0);
      chk("bad_words", words_loaded, 0);
      chk("bad_addr", addr_ext, BASE);
      repeat (3) tick();
      chk("bad_start_held_low", start, 0);
      chk("bad_no_write", iram_write_ext, 0);
    end else begin
      chk("ok_done", done, 1);
      chk("ok_error", error, (ovr >= 0 && ovr < n) ? 1 : 0);
      chk("ok_words", words_loaded, n);
      chk("ok_addr", addr_ext, BASE + n);
      chk("ok_data_hold", Data_in_ins, wbuf[n-1]);
      tick();
      chk("ok_start_second_cycle", start, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int ws;
    logic [15:0] cnt;
    reset = 1'b1; load_en = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_start_2", start_2, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_addr", addr_ext, BASE);
    chk("rst_write", iram_write_ext, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_data", Data_in_ins, 0);

    // Two-word load with hand-computed results.
    ws = writes_seen;
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    run_load(16'd2, 0, -1);
    chk("t1_writes", writes_seen - ws, 2);
    chk("t1_addr_lit", addr_ext, 3);
    chk("t1_data_lit", Data_in_ins, 16'hABCD);
    chk("t1_words_lit", words_loaded, 2);

    // Zero and oversize counts.
    ws = writes_seen;
    run_load(16'd0, 0, -1);
    run_load(16'd512, 1, -1);
    chk("t23_no_writes", writes_seen - ws, 0);

    // Overrun byte during the first word's write pulse.
    wbuf[0] = 16'h5A5A; wbuf[1] = 16'hC3C3;
    run_load(16'd2, 0, 0);
    chk("t4_error_lit", error, 1);
    chk("t4_start_lit", start, 1);

    // Reset on the second WRITE cycle, then a clean load.
    load_en = 1'b1; tick(); load_en = 1'b0;
    wbuf[0] = 16'h1234; wbuf[1] = 16'h9876;
    begin wr_t w; w.a = ADDR_W'(BASE); w.d = 16'h1234; exp_q.push_back(w); end
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    ws = 0;
    while (!iram_write_ext && ws < 20) begin tick(); ws++; end
    tick();
    chk("t5_in_write", iram_write_ext, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q.delete();
    chk("t5_write_low", iram_write_ext, 0);
    chk("t5_start_2", start_2, 0);
    chk("t5_busy", busy, 0);
    chk("t5_addr", addr_ext, BASE);
    chk("t5_words", words_loaded, 0);
    tick();
    chk("t5_write_stays_low", iram_write_ext, 0);
    wbuf[0] = 16'h0001; wbuf[1] = 16'h8000; wbuf[2] = 16'h7FFE;
    run_load(16'd3, -1, -1);

    // Reload after DONE: single 0xFFFF word, bytes spaced by one idle cycle.
    wbuf[0] = 16'hFFFF;
    run_load(16'd1, 1, -1);
    chk("t6_addr_lit", addr_ext, 2);
    chk("t6_data_lit", Data_in_ins, 16'hFFFF);

    // Randomised loads.
    for (int r = 0; r < 25; r++) begin
      int ovr = -1;
      if ($urandom_range(0, 9) == 0)
        cnt = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'($urandom_range(512, 65535));
      else
        cnt = 16'($urandom_range(1, 6));
      for (int i = 0; i < 64; i++) wbuf[i] = 16'($urandom);
      if (cnt != 0 && cnt <= 16'd6 && $urandom_range(0, 4) == 0)
        ovr = int'($urandom_range(0, int'(cnt) - 1));
      run_load(cnt, -1, ovr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
